// File: rtl/digit_entry_ctrl.sv
// Front-panel digit editor: button-driven digit/cursor edits, then serial radix conversion into op_a/op_b.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on btn_up/btn_down.
module digit_entry_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int SPLIT         = 2,
    parameter int RADIX         = 10,
    parameter int OUT_W         = 32,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_commit,
    input  logic                    btn_clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [CUR_W-1:0]        cursor,
    output logic [OUT_W-1:0]        op_a,
    output logic [OUT_W-1:0]        op_b,
    output logic                    op_valid,
    output logic                    busy
);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 2..8");
    end
    if (SPLIT < 1 || SPLIT > NUM_DIGITS - 1) begin : g_bad_split
        $error("SPLIT must be in 1..NUM_DIGITS-1");
    end
    if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
        $error("RADIX must be 10 or 16");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("HOLD_CYCLES and REPEAT_CYCLES must be positive");
    end

    localparam logic [CUR_W-1:0] LAST_IDX  = CUR_W'(NUM_DIGITS - 1);
    localparam logic [CUR_W-1:0] SPLIT_IDX = CUR_W'(SPLIT);
    localparam logic [3:0]       DIG_MAX   = 4'(RADIX - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                     state, state_nxt;
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [CUR_W-1:0]           cur, idx;
    logic [OUT_W-1:0]           acc_a, acc_b, acc_src, mac;
    logic                       up_q, down_q, left_q, right_q, commit_q, clear_q;
    logic                       rise_up, rise_down, rise_left, rise_right, rise_commit, rise_clear;
    logic                       ev_up, ev_down;
    logic [3:0]                 sel, sel_inc, sel_dec;

    assign rise_up     = btn_up & ~up_q;
    assign rise_down   = btn_down & ~down_q;
    assign rise_left   = btn_left & ~left_q;
    assign rise_right  = btn_right & ~right_q;
    assign rise_commit = btn_commit & ~commit_q;
    assign rise_clear  = btn_clear & ~clear_q;

    assign sel     = dig[cur];
    assign sel_inc = (sel == DIG_MAX) ? 4'd0 : sel + 4'd1;
    assign sel_dec = (sel == 4'd0) ? DIG_MAX : sel - 4'd1;

    // Digits above SPLIT accumulate into op_a, the rest into op_b, MSD first.
    assign acc_src = (idx >= SPLIT_IDX) ? acc_a : acc_b;
    assign mac     = acc_src * OUT_W'(RADIX) + OUT_W'(dig[idx]);

`ifdef AUTO_REPEAT_EN
    logic [31:0] hold_cnt;
    logic        hold_rep, hold_on, hold_same, rep_fire;

    always_comb begin
        hold_on   = (btn_up ^ btn_down) && (state == IDLE);
        hold_same = (btn_up && up_q) || (btn_down && down_q);
        rep_fire  = hold_on && hold_same &&
                    (hold_cnt == (hold_rep ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES)));
    end

    // hold_cnt counts qualifying held cycles since the last press or repeat.
    always_ff @(posedge clk) begin
        if (!rst_n || !hold_on) begin
            hold_cnt <= '0;
            hold_rep <= 1'b0;
        end else if (!hold_same) begin
            hold_cnt <= 32'd1;
            hold_rep <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt <= 32'd1;
            hold_rep <= 1'b1;
        end else begin
            hold_cnt <= hold_cnt + 32'd1;
        end
    end

    assign ev_up   = rise_up | (rep_fire & btn_up);
    assign ev_down = rise_down | (rep_fire & btn_down);
`else
    assign ev_up   = rise_up;
    assign ev_down = rise_down;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (rise_commit) state_nxt = CONV;
            CONV:    if (idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig      <= '0;
            cur      <= '0;
            idx      <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            commit_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            up_q     <= btn_up;
            down_q   <= btn_down;
            left_q   <= btn_left;
            right_q  <= btn_right;
            commit_q <= btn_commit;
            clear_q  <= btn_clear;
            op_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Only the highest-priority edge acts; the rest are consumed.
                    if (rise_commit) begin
                        acc_a <= '0;
                        acc_b <= '0;
                        idx   <= LAST_IDX;
                    end else if (rise_clear) begin
                        dig <= '0;
                        cur <= '0;
                    end else if (ev_up) begin
                        dig[cur] <= sel_inc;
                    end else if (ev_down) begin
                        dig[cur] <= sel_dec;
                    end else if (rise_left) begin
                        cur <= (cur == LAST_IDX) ? '0 : cur + CUR_W'(1);
                    end else if (rise_right) begin
                        cur <= (cur == '0) ? LAST_IDX : cur - CUR_W'(1);
                    end
                end
                CONV: begin
                    if (idx >= SPLIT_IDX) acc_a <= mac;
                    else                  acc_b <= mac;
                    idx <= idx - CUR_W'(1);
                end
                DONE: begin
                    op_a     <= acc_a;
                    op_b     <= acc_b;
                    op_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign digits = dig;
    assign cursor = cur;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Bench for digit_entry_ctrl: radix-10 and radix-16 instances share stimulus; a per-edge reference model predicts both.
`timescale 1ns/1ps
module tb_digit_entry_ctrl;

    localparam int N     = 4;
    localparam int SPLIT = 2;
    localparam int HOLD  = 8;
    localparam int REP   = 4;

`ifdef AUTO_REPEAT_EN
    localparam int EXP_HOLD = 4;
`else
    localparam int EXP_HOLD = 1;
`endif

    localparam logic [5:0] B_COMMIT = 6'b100000;
    localparam logic [5:0] B_CLEAR  = 6'b010000;
    localparam logic [5:0] B_UP     = 6'b001000;
    localparam logic [5:0] B_DOWN   = 6'b000100;
    localparam logic [5:0] B_LEFT   = 6'b000010;
    localparam logic [5:0] B_RIGHT  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  btn = '0;

    logic [15:0] digits10, digits16;
    logic [1:0]  cursor10, cursor16;
    logic [31:0] op_a10, op_b10, op_a16, op_b16;
    logic        valid10, valid16, busy10, busy16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_entry_ctrl #(.NUM_DIGITS(N), .SPLIT(SPLIT), .RADIX(10), .OUT_W(32),
                       .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .btn_commit(btn[5]), .btn_clear(btn[4]),
        .digits(digits10), .cursor(cursor10), .op_a(op_a10), .op_b(op_b10),
        .op_valid(valid10), .busy(busy10));

    digit_entry_ctrl #(.NUM_DIGITS(N), .SPLIT(SPLIT), .RADIX(16), .OUT_W(32),
                       .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .btn_commit(btn[5]), .btn_clear(btn[4]),
        .digits(digits16), .cursor(cursor16), .op_a(op_a16), .op_b(op_b16),
        .op_valid(valid16), .busy(busy16));

    // Reference model: index 0 predicts the radix-10 instance, index 1 the radix-16 one.
    int          m_dig [2][N];
    int          m_cur;
    logic [31:0] m_opa [2];
    logic [31:0] m_opb [2];
    logic [31:0] m_pa  [2];
    logic [31:0] m_pb  [2];
    bit          m_valid;
    int          m_busy_cnt;
    int          m_run;
    int          m_run_btn;
    logic [5:0]  m_prev;

    function automatic int radix(input int k);
        return (k == 0) ? 10 : 16;
    endfunction

    function automatic logic [15:0] exp_digits(input int k);
        logic [15:0] r;
        r = '0;
        for (int d = 0; d < N; d++) r[4*d +: 4] = 4'(m_dig[k][d]);
        return r;
    endfunction

    function automatic logic [83:0] exp_bundle(input int k);
        return {exp_digits(k), 2'(m_cur), m_opa[k], m_opb[k], m_valid, (m_busy_cnt > 0)};
    endfunction

    task automatic model_edge(input logic [5:0] b, input logic r);
        logic [5:0] rise;
        bit         busy_pre, fire_up, fire_dn;
        int         pw;
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                for (int d = 0; d < N; d++) m_dig[k][d] = 0;
                m_opa[k] = '0; m_opb[k] = '0; m_pa[k] = '0; m_pb[k] = '0;
            end
            m_cur = 0; m_valid = 0; m_busy_cnt = 0; m_run = 0; m_run_btn = 0; m_prev = '0;
        end else begin
            rise     = b & ~m_prev;
            m_prev   = b;
            busy_pre = (m_busy_cnt > 0);
            m_valid  = 0;
            fire_up  = 0;
            fire_dn  = 0;
`ifdef AUTO_REPEAT_EN
            if ((b[3] ^ b[2]) && !busy_pre) begin
                if (m_run > 0 && m_run_btn == int'(b[3])) begin
                    if (m_run >= HOLD && (m_run - HOLD) % REP == 0) begin
                        fire_up = b[3];
                        fire_dn = b[2];
                    end
                    m_run++;
                end else begin
                    m_run     = 1;
                    m_run_btn = int'(b[3]);
                end
            end else begin
                m_run = 0;
            end
`endif
            if (busy_pre) begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_valid = 1;
                    for (int k = 0; k < 2; k++) begin
                        m_opa[k] = m_pa[k];
                        m_opb[k] = m_pb[k];
                    end
                end
            end else if (rise[5]) begin
                for (int k = 0; k < 2; k++) begin
                    m_pa[k] = '0; m_pb[k] = '0; pw = 1;
                    for (int d = 0; d < N; d++) begin
                        if (d == SPLIT) pw = 1;
                        if (d < SPLIT) m_pb[k] += 32'(m_dig[k][d] * pw);
                        else           m_pa[k] += 32'(m_dig[k][d] * pw);
                        pw *= radix(k);
                    end
                end
                m_busy_cnt = N + 1;
            end else if (rise[4]) begin
                for (int k = 0; k < 2; k++)
                    for (int d = 0; d < N; d++) m_dig[k][d] = 0;
                m_cur = 0;
            end else if (rise[3] || fire_up) begin
                for (int k = 0; k < 2; k++) m_dig[k][m_cur] = (m_dig[k][m_cur] + 1) % radix(k);
            end else if (rise[2] || fire_dn) begin
                for (int k = 0; k < 2; k++)
                    m_dig[k][m_cur] = (m_dig[k][m_cur] + radix(k) - 1) % radix(k);
            end else if (rise[1]) begin
                m_cur = (m_cur + 1) % N;
            end else if (rise[0]) begin
                m_cur = (m_cur + N - 1) % N;
            end
        end
    endtask

    task automatic tick(input logic [5:0] b, input logic r);
        @(negedge clk);
        btn   = b;
        rst_n = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
    endtask

    task automatic press(input logic [5:0] b);
        tick(b, 1'b1);
        tick('0, 1'b1);
    endtask

    task automatic test_reset();
        tick('0, 1'b0);
        tick('0, 1'b0);
        n_vec++;
        if ({digits10, cursor10, op_a10, op_b10, valid10, busy10} !== 84'h0) begin
            n_err++;
            $display("FAIL reset10: got %h want 0", {digits10, cursor10, op_a10, op_b10, valid10, busy10});
        end
        n_vec++;
        if ({digits16, cursor16, op_a16, op_b16, valid16, busy16} !== 84'h0) begin
            n_err++;
            $display("FAIL reset16: got %h want 0", {digits16, cursor16, op_a16, op_b16, valid16, busy16});
        end
    endtask

    task automatic test_entry();
        int seen;
        tick('0, 1'b1);
        repeat (3) press(B_UP);
        press(B_LEFT);
        press(B_UP);
        n_vec++;
        if (digits10 !== 16'h0013 || cursor10 !== 2'd1) begin
            n_err++;
            $display("FAIL entry_digits: got %h cur %0d want 0013 cur 1", digits10, cursor10);
        end
        tick(B_COMMIT, 1'b1);
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            tick('0, 1'b1);
            if (valid10) begin
                seen++;
                n_vec++;
                if (i != 5) begin
                    n_err++;
                    $display("FAIL entry_latency: valid after %0d edges want 5", i);
                end
            end
        end
        n_vec++;
        if (seen != 1) begin
            n_err++;
            $display("FAIL entry_pulses: got %0d want 1", seen);
        end
        n_vec++;
        if (op_a10 !== 32'd0 || op_b10 !== 32'd13 || op_a16 !== 32'd0 || op_b16 !== 32'h13) begin
            n_err++;
            $display("FAIL entry_ops: got %0d %0d %h %h want 0 13 0 13", op_a10, op_b10, op_a16, op_b16);
        end
    endtask

    task automatic test_wraps();
        tick('0, 1'b0);
        repeat (4) press(B_DOWN);
        press(B_RIGHT);
        press(B_DOWN);
        press(B_RIGHT);
        repeat (2) press(B_DOWN);
        press(B_RIGHT);
        repeat (3) press(B_DOWN);
        n_vec++;
        if (digits10 !== 16'h9876 || digits16 !== 16'hFEDC || cursor10 !== 2'd1) begin
            n_err++;
            $display("FAIL wrap_digits: got %h %h cur %0d want 9876 FEDC cur 1", digits10, digits16, cursor10);
        end
        tick(B_COMMIT, 1'b1);
        repeat (6) tick('0, 1'b1);
        n_vec++;
        if (op_a10 !== 32'd98 || op_b10 !== 32'd76 || op_a16 !== 32'd254 || op_b16 !== 32'd220) begin
            n_err++;
            $display("FAIL wrap_ops: got %0d %0d %0d %0d want 98 76 254 220", op_a10, op_b10, op_a16, op_b16);
        end
        press(B_CLEAR);
        repeat (6) press(B_DOWN);
        press(B_RIGHT);
        press(B_DOWN);
        press(B_RIGHT);
        press(B_DOWN);
        n_vec++;
        if (digits10 !== 16'h9904 || digits16 !== 16'hFF0A || cursor16 !== 2'd2) begin
            n_err++;
            $display("FAIL hex_digits: got %h %h cur %0d want 9904 FF0A cur 2", digits10, digits16, cursor16);
        end
        tick(B_COMMIT, 1'b1);
        repeat (6) tick('0, 1'b1);
        n_vec++;
        if (op_a16 !== 32'd255 || op_b16 !== 32'd10 || op_a10 !== 32'd99 || op_b10 !== 32'd4) begin
            n_err++;
            $display("FAIL hex_ops: got %0d %0d %0d %0d want 255 10 99 4", op_a16, op_b16, op_a10, op_b10);
        end
    endtask

    task automatic test_busy_lockout();
        logic [5:0] seq [5];
        int pulses, busies;
        seq = '{B_UP, B_LEFT, B_CLEAR, B_COMMIT, 6'b0};
        tick(B_COMMIT, 1'b1);
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 11; i++) begin
            tick((i < 5) ? seq[i] : 6'b0, 1'b1);
            pulses += int'(valid10);
            busies += int'(busy10);
        end
        n_vec++;
        if (pulses != 1 || busies != 4) begin
            n_err++;
            $display("FAIL busy_pulses: got valid %0d busy %0d want 1 4", pulses, busies);
        end
        n_vec++;
        if (digits10 !== 16'h9904 || digits16 !== 16'hFF0A || cursor10 !== 2'd2 || op_a16 !== 32'd255) begin
            n_err++;
            $display("FAIL busy_hold: got %h %h cur %0d opa %0d want 9904 FF0A 2 255",
                     digits10, digits16, cursor10, op_a16);
        end
    endtask

    task automatic test_reset_mid_conv();
        int pulses;
        tick(B_COMMIT, 1'b1);
        tick('0, 1'b1);
        tick('0, 1'b0);
        n_vec++;
        if ({digits10, cursor10, op_a10, op_b10, valid10, busy10,
             digits16, cursor16, op_a16, op_b16, valid16, busy16} !== 168'h0) begin
            n_err++;
            $display("FAIL midreset: got %h / %h want 0", {digits10, cursor10, op_a10, op_b10, valid10, busy10},
                     {digits16, cursor16, op_a16, op_b16, valid16, busy16});
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick('0, 1'b1);
            pulses += int'(valid10) + int'(valid16);
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL midreset_valid: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_same_cycle();
        tick(B_UP | B_LEFT, 1'b1);
        n_vec++;
        if (digits10 !== 16'h0001 || cursor10 !== 2'd0) begin
            n_err++;
            $display("FAIL up_left: got %h cur %0d want 0001 cur 0", digits10, cursor10);
        end
        tick('0, 1'b1);
        press(B_UP);
        tick(B_CLEAR | B_UP, 1'b1);
        n_vec++;
        if (digits10 !== 16'h0 || digits16 !== 16'h0) begin
            n_err++;
            $display("FAIL clear_up: got %h %h want 0000", digits10, digits16);
        end
        tick('0, 1'b1);
    endtask

    task automatic test_auto_repeat();
        tick('0, 1'b0);
        repeat (20) tick(B_UP, 1'b1);
        tick('0, 1'b1);
        n_vec++;
        if (digits10 !== 16'(EXP_HOLD) || digits16 !== 16'(EXP_HOLD)) begin
            n_err++;
            $display("FAIL hold_up: got %h %h want %0d", digits10, digits16, EXP_HOLD);
        end
    endtask

    task automatic test_random();
        logic [5:0] b;
        int len, r;
        tick('0, 1'b0);
        b = '0;
        len = 0;
        for (int i = 0; i < 600; i++) begin
            if (len == 0) begin
                r = $urandom_range(0, 9);
                if (r < 3)      b = '0;
                else if (r < 8) b = 6'(1 << $urandom_range(0, 5));
                else            b = 6'($urandom_range(0, 63));
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 3);
            end
            len--;
            tick(b, ($urandom_range(0, 99) != 0));
            n_vec++;
            if ({digits10, cursor10, op_a10, op_b10, valid10, busy10} !== exp_bundle(0)) begin
                n_err++;
                $display("FAIL rand10 @%0d: got %h want %h", i,
                         {digits10, cursor10, op_a10, op_b10, valid10, busy10}, exp_bundle(0));
            end
            n_vec++;
            if ({digits16, cursor16, op_a16, op_b16, valid16, busy16} !== exp_bundle(1)) begin
                n_err++;
                $display("FAIL rand16 @%0d: got %h want %h", i,
                         {digits16, cursor16, op_a16, op_b16, valid16, busy16}, exp_bundle(1));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_entry();
        test_wraps();
        test_busy_lockout();
        test_reset_mid_conv();
        test_same_cycle();
        test_auto_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
Parametrised front-panel operand entry controller for the Basys3 CPU top. It takes debounced button levels and maintains NUM_DIGITS editable digits in radix 10 or 16, with cursor movement and optional auto-repeat on held up/down. On commit it serially converts the digit fields into two binary operands and hands them to the CPU with a one-cycle valid pulse. The digit vector also feeds seg_display directly.

Parameters:
NUM_DIGITS, 4, number of editable digits (2..8); digit 0 is least significant/rightmost
SPLIT, 2, digits [SPLIT-1:0] form op_b, digits [NUM_DIGITS-1:SPLIT] form op_a (1..NUM_DIGITS-1)
RADIX, 10, digit range 0..RADIX-1; only 10 or 16 legal
OUT_W, 32, operand width
HOLD_CYCLES, 50000000, held cycles before first auto-repeat
REPEAT_CYCLES, 10000000, cycles between subsequent repeats

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
btn_up  in  1  debounced level, high while held: current digit +1
btn_down  in  1  debounced level: current digit -1
btn_left  in  1  debounced level: cursor toward MSD
btn_right  in  1  debounced level: cursor toward LSD
btn_commit  in  1  debounced level: start conversion on rising edge
btn_clear  in  1  debounced level: zero all digits on rising edge
digits  out  4*NUM_DIGITS  digit d at bits [4d+3:4d]
cursor  out  CUR_W=max(1,clog2(NUM_DIGITS))  selected digit index
op_a  out  OUT_W  committed operand A
op_b  out  OUT_W  committed operand B
op_valid  out  1  one-cycle pulse when op_a/op_b update
busy  out  1  conversion in progress

Behaviour:
- Reset (rst_n low at clk edge): digits=0, cursor=0, op_a=op_b=0, op_valid=0, busy=0, FSM=IDLE, edge registers and hold counter cleared. Applies mid-conversion; partial results are discarded.
- Rising edges are detected against a registered copy of each input. Actions take effect on the clock edge after the rising edge is sampled.
- Several rising edges in one cycle: only the highest priority acts, in the order commit > clear > up > down > left > right. The other edges are consumed and not deferred.
- up: digit[cursor] = (d==RADIX-1) ? 0 : d+1. down: (d==0) ? RADIX-1 : d-1.
- left: cursor = (cursor==NUM_DIGITS-1) ? 0 : cursor+1. right: cursor = (cursor==0) ? NUM_DIGITS-1 : cursor-1.
- clear: all digits=0, cursor=0. op_a and op_b are unchanged.
- FSM IDLE -> CONV on commit edge.
  - Entering CONV: acc_a=acc_b=0, idx=NUM_DIGITS-1.
  - Each CONV cycle processes digit idx: acc = acc*RADIX + digit[idx], into acc_a if idx>=SPLIT, else acc_b. Then idx decrements.
  - After idx 0 is processed, the FSM goes to DONE. CONV lasts exactly NUM_DIGITS cycles.
- DONE (1 cycle): op_a<=acc_a, op_b<=acc_b, op_valid=1, then IDLE.
- Commit edge sampled at cycle k gives op_valid high at cycle k+NUM_DIGITS+1, with new op_a/op_b visible in the same cycle.
- busy=1 in CONV and DONE. While busy, every button edge (including commit) is dropped and the hold counter is held at 0.
- Digits are snapshotted: edits cannot occur while busy, so conversion uses the digit values present at commit.
- Arithmetic is modulo 2^OUT_W. Overflow silently truncates.
- RADIX=16 conversion equals a plain nibble concatenation.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined:
  - A hold counter runs while exactly one of btn_up/btn_down is high and not busy.
  - After HOLD_CYCLES cycles of continuous hold, one extra repeat action fires. Another fires every REPEAT_CYCLES cycles thereafter.
  - Release, a change of button, or busy resets the counter.
  - left/right never repeat.
- Undefined: no counter logic is synthesised. Each press gives exactly one action, however long it is held.

Test Plan:
1. Defaults (NUM_DIGITS=4, SPLIT=2, RADIX=10). Reset, then press up 3x at cursor 0, left, up 1x, then commit -> digits=16'h0013, op_a=0, op_b=13, op_valid exactly 5 cycles after commit edge sampled.
2. Digits 9,8,7,6 (MSD..LSD) entered via up/down/left/right wraps (down from 0 -> 9; right from 0 -> cursor 3) -> commit gives op_a=98, op_b=76. Repeat with RADIX=16 and digits F,F,0,A -> op_a=255, op_b=10.
3. Press commit, then toggle up/left/clear during busy -> digits and cursor unchanged, single op_valid pulse, a second commit during busy ignored.
4. Assert rst_n low at the 2nd CONV cycle -> next cycle all outputs 0, no op_valid ever pulses.
5. Same-cycle rising edges on up+left -> only up acts. Same-cycle clear+up -> digits all 0.
6. AUTO_REPEAT_EN with HOLD_CYCLES=8, REPEAT_CYCLES=4: hold up for 20 cycles from digit 0 -> digit=4 (press + repeats at 8,12,16). Without the macro -> digit=1.
